cordic_arbiter: RTL

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one CORDIC pipeline
// between two angle requesters, with tagged results.
module cordic_arbiter #(
  parameter int WIDTH    = 16,
  parameter int LATENCY  = 16,
  parameter int XIN_INIT = 19429
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             req0_valid,
  input  logic [31:0]      req0_angle,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_angle,
  output logic             req1_ready,
  output logic [31:0]      cordic_angle,
  output logic [WIDTH-1:0] cordic_xin,
  output logic [WIDTH-1:0] cordic_yin,
  input  logic [WIDTH-1:0] cordic_xout,
  input  logic [WIDTH-1:0] cordic_yout,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_cos,
  output logic [WIDTH-1:0] rsp_sin,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             prio_q, prio_d;
  logic [31:0]      angle_q, angle_d;
  logic [LATENCY:0] tv_q, tid_q;
  logic             rv_q;
  logic             rid_q, rid_d;
  logic [WIDTH-1:0] cos_q, cos_d;
  logic [WIDTH-1:0] sin_q, sin_d;
  logic             gnt0, gnt1, accept;

  assign cordic_xin   = WIDTH'(XIN_INIT);
  assign cordic_yin   = '0;
  assign cordic_angle = angle_q;
  assign req0_ready   = gnt0;
  assign req1_ready   = gnt1;
  assign rsp_valid    = rv_q;
  assign rsp_id       = rid_q;
  assign rsp_cos      = cos_q;
  assign rsp_sin      = sin_q;
  assign busy         = |tv_q;
  assign accept       = gnt0 | gnt1;

  // prio_q names the requester that wins a tie
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_RUN && enable) begin
      case ({req1_valid, req0_valid})
        2'b01:   gnt0 = 1'b1;
        2'b10:   gnt1 = 1'b1;
        2'b11: begin
          gnt0 = ~prio_q;
          gnt1 = prio_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prio_d  = prio_q;
    angle_d = angle_q;
    if (gnt0) begin
      prio_d  = 1'b1;
      angle_d = req0_angle;
    end else if (gnt1) begin
      prio_d  = 1'b0;
      angle_d = req1_angle;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (enable) state_d = S_RUN;
      S_RUN:
        if (!enable) state_d = busy ? S_DRAIN : S_IDLE;
      S_DRAIN:
        if (enable)     state_d = S_RUN;
        else if (!busy) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rid_d = rid_q;
    cos_d = cos_q;
    sin_d = sin_q;
    if (tv_q[LATENCY]) begin
      rid_d = tid_q[LATENCY];
      cos_d = cordic_xout;
      sin_d = cordic_yout;
    end
  end

  // Tag stage 0 sits beside cordic_angle; the rest
  // track the CORDIC stages so the last one lines up
  // with the matching xout/yout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      angle_q <= '0;
      tv_q    <= '0;
      tid_q   <= '0;
      rv_q    <= 1'b0;
      rid_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      angle_q <= angle_d;
      tv_q    <= {tv_q[LATENCY-1:0], accept};
      tid_q   <= {tid_q[LATENCY-1:0], gnt1};
      rv_q    <= tv_q[LATENCY];
      rid_q   <= rid_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

endmodule
